// File: rtl/sdma_pkg.sv
// sdma_pkg: acquisition sequencer state encoding and error codes
package sdma_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, ARM, CAPTURE, DONE, ERROR} acq_state_t;
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_SETTLE = 2'd1;
    localparam logic [1:0] ERR_TRIG   = 2'd2;
    localparam logic [1:0] ERR_LOST   = 2'd3;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-FF synchronizer with registered rising-edge pulse (3-cycle latency)
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            pulse <= 1'b0;
        end else begin
            sr    <= {sr[1:0], d};
            pulse <= sr[1] & ~sr[2];
        end
    end
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: settle/arm/capture sequencer driving the ping-pong buffer write port
module acq_sequencer
    import sdma_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int HOLD_CYC  = 16,
    parameter int SETTLE_TO = 2_000_000,
    parameter int TRIG_TO   = 4_000_000,
    parameter int CNT_W     = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cont,
    input  logic              gain_stable,
    input  logic              freq_stable,
    input  logic              signal_in,
    input  logic              adc_clk,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              buf_sel,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [15:0]       frame_cnt
);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    acq_state_t state, state_nxt;
    logic [1:0] err_nxt;
    logic [HOLD_W-1:0] hold;
    logic [CNT_W-1:0] to_cnt;
    logic [ADDR_W-1:0] addr;
    logic sig_pulse, adc_pulse, stable, last_wr;
    logic wr_d, busy_d, done_d;
    assign stable  = gain_stable & freq_stable;
    assign last_wr = adc_pulse && addr == ADDR_W'(DEPTH - 1);
    edge_sync u_sig (.clk(clk), .rst_n(rst_n), .d(signal_in), .pulse(sig_pulse));
    edge_sync u_adc (.clk(clk), .rst_n(rst_n), .d(adc_clk), .pulse(adc_pulse));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            IDLE, ERROR: begin
                if (start) begin
                    state_nxt = SETTLE;
                    err_nxt   = ERR_NONE;
                end
            end
            SETTLE: begin
                if (stable && hold == HOLD_W'(HOLD_CYC - 1)) begin
                    state_nxt = ARM;
                end else if (to_cnt == CNT_W'(SETTLE_TO - 1)) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_SETTLE;
                end
            end
            ARM: begin
                if (!stable) begin
                    state_nxt = SETTLE;
                end else if (sig_pulse) begin
                    state_nxt = CAPTURE;
                end else if (to_cnt == CNT_W'(TRIG_TO - 1)) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_TRIG;
                end
            end
            CAPTURE: begin
                // a drop coinciding with the final write still counts as lost
                if (!stable) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_LOST;
                end else if (last_wr) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = cont ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            err_nxt   = err_code;
        end
    end
    always_comb begin
        wr_d   = state == CAPTURE && stable && adc_pulse && !abort;
        busy_d = state_nxt != IDLE && state_nxt != ERROR;
        done_d = state_nxt == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold        <= '0;
            to_cnt      <= '0;
            addr        <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_sel     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= ERR_NONE;
            frame_cnt   <= '0;
        end else begin
            hold        <= (state == SETTLE && state_nxt == SETTLE && stable) ? hold + 1'b1 : '0;
            to_cnt      <= (state_nxt == state && (state == SETTLE || state == ARM)) ? to_cnt + 1'b1 : '0;
            addr        <= (state == CAPTURE && state_nxt == CAPTURE) ? addr + ADDR_W'(wr_d) : '0;
            buf_wr_en   <= wr_d;
            buf_wr_addr <= (state != CAPTURE && state_nxt == CAPTURE) ? '0 : wr_d ? addr : buf_wr_addr;
            buf_sel     <= buf_sel ^ done_d;
            busy        <= busy_d;
            done        <= done_d;
            err_code    <= err_nxt;
            frame_cnt   <= frame_cnt + 16'(done_d);
        end
    end
endmodule
